// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Test-pattern source for a VGA controller. The controller supplies the
//   current pixel coordinate and a visible-area flag. This block returns the
//   pixel colour one clock later. The displayed mode changes only at the frame
//   boundary, where x==0 and y==0. Mode 5 is a 2-D bouncing block. It moves at
//   most one step per frame, and only when a move has been requested by the
//   free-running tick counter.
//
// Ports
//   clk_25M   in   1        pixel clock
//   reset     in   1        synchronous, active-high
//   sel       in   3        pattern select switches
//   block_en  in   1        forces bouncing-block mode (overrides sel)
//   x, y      in   COORD_W  current pixel column / row
//   active    in   1        visible-area flag
//   color     out  COLOR_W  registered pixel colour, 4R:4G:4B
//   mode      out  3        mode currently displayed (3'b101 = bounce)
module vga_pattern_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int COORD_W   = 11,
  parameter int COLOR_W   = 12,
  parameter int BAR_W     = 16,
  parameter int STRIPE_H  = 32,
  parameter int CORNER_SZ = 128,
  parameter int BLOCK_SZ  = 32,
  parameter int STEP      = 4,
  parameter int TICK_DIV  = 6_250_000
) (
  input  logic               clk_25M,
  input  logic               reset,
  input  logic [2:0]         sel,
  input  logic               block_en,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               active,
  output logic [COLOR_W-1:0] color,
  output logic [2:0]         mode
);

  localparam int BAR_BIT = $clog2(BAR_W);
  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [COORD_W:0]   LIM_X     = (COORD_W+1)'(H_ACTIVE - BLOCK_SZ);
  localparam logic [COORD_W:0]   LIM_Y     = (COORD_W+1)'(V_ACTIVE - BLOCK_SZ);
  localparam logic [COORD_W:0]   STEP_V    = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0]   BLK_V     = (COORD_W+1)'(BLOCK_SZ);
  localparam logic [COORD_W-1:0] STRIPE_Y  = COORD_W'(V_ACTIVE - STRIPE_H);
  localparam logic [COORD_W-1:0] CORNER_Y  = COORD_W'(CORNER_SZ);
  localparam logic [COORD_W-1:0] CORNER_X  = COORD_W'(H_ACTIVE - CORNER_SZ);
  localparam logic [COORD_W-1:0] POS_X_RST = COORD_W'((H_ACTIVE - BLOCK_SZ) / 2);

  localparam logic [COLOR_W-1:0] C_BLACK  = '0;
  localparam logic [COLOR_W-1:0] C_RED    = COLOR_W'(12'hF00);
  localparam logic [COLOR_W-1:0] C_GREEN  = COLOR_W'(12'h0F0);
  localparam logic [COLOR_W-1:0] C_BLUE   = COLOR_W'(12'h00F);
  localparam logic [COLOR_W-1:0] C_YELLOW = COLOR_W'(12'hFF0);
  localparam logic [COLOR_W-1:0] C_WHITE  = COLOR_W'(12'hFFF);

  localparam logic [2:0] MODE_BOUNCE = 3'd5;

  logic [TICK_W-1:0]  tick_cnt;
  logic               move_pend;
  logic [COORD_W-1:0] pos_x, pos_y;
  logic               dir_x, dir_y;          // 1 = moving towards the limit

  logic               fb, tick_tc, step_en, pend_nxt;
  logic [2:0]         mode_nxt;
  logic [COORD_W-1:0] pos_x_nxt, pos_y_nxt;
  logic               dir_x_nxt, dir_y_nxt;
  logic [COLOR_W-1:0] pattern;
  logic               in_block;

  // One step along one axis; returns {dir, pos}. The clamp to 0 or lim and
  // the direction flip happen together, so pos can never leave 0..lim.
  function automatic logic [COORD_W:0] step_axis(input logic [COORD_W-1:0] pos,
                                                 input logic dir,
                                                 input logic [COORD_W:0] lim);
    logic [COORD_W:0] ext;
    ext = {1'b0, pos};
    if (dir) begin
      if (ext + STEP_V >= lim) return {1'b0, lim[COORD_W-1:0]};
      return {1'b1, pos + STEP_V[COORD_W-1:0]};
    end
    if (ext <= STEP_V) return {1'b1, {COORD_W{1'b0}}};
    return {1'b0, pos - STEP_V[COORD_W-1:0]};
  endfunction

  assign fb      = (x == '0) && (y == '0);
  assign tick_tc = (tick_cnt == TICK_LAST);

  // The boundary pixel already belongs to the new frame. It is drawn with
  // the new mode and position, so the whole frame is consistent.
  always_comb begin
    mode_nxt  = fb ? (block_en ? MODE_BOUNCE : sel) : mode;
    step_en   = fb && move_pend && (mode_nxt == MODE_BOUNCE);
    // A tick on the same edge as a consumed request re-arms it for the next frame.
    pend_nxt  = tick_tc | (move_pend & ~step_en);
    pos_x_nxt = pos_x;
    pos_y_nxt = pos_y;
    dir_x_nxt = dir_x;
    dir_y_nxt = dir_y;
    if (step_en) begin
      {dir_x_nxt, pos_x_nxt} = step_axis(pos_x, dir_x, LIM_X);
      {dir_y_nxt, pos_y_nxt} = step_axis(pos_y, dir_y, LIM_Y);
    end
  end

  always_comb begin
    in_block = ({1'b0, x} >= {1'b0, pos_x_nxt}) && ({1'b0, x} < {1'b0, pos_x_nxt} + BLK_V) &&
               ({1'b0, y} >= {1'b0, pos_y_nxt}) && ({1'b0, y} < {1'b0, pos_y_nxt} + BLK_V);
    pattern = C_YELLOW;
    case (mode_nxt)
      3'd1:    pattern = x[BAR_BIT] ? C_WHITE : C_RED;
      3'd2:    pattern = (y >= STRIPE_Y) ? C_BLUE : C_BLACK;
      3'd3:    pattern = ((y < CORNER_Y) && (x >= CORNER_X)) ? C_GREEN : C_BLACK;
      3'd4:    pattern = (x[BAR_BIT] ^ y[BAR_BIT]) ? C_BLACK : C_WHITE;
      3'd5:    pattern = in_block ? C_RED : C_BLUE;
      default: pattern = C_YELLOW;
    endcase
  end

  always_ff @(posedge clk_25M) begin
    if (reset) begin
      color     <= C_BLACK;
      mode      <= 3'd0;
      tick_cnt  <= '0;
      move_pend <= 1'b0;
      pos_x     <= POS_X_RST;
      pos_y     <= '0;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
    end else begin
      color     <= active ? pattern : C_BLACK;
      mode      <= mode_nxt;
      tick_cnt  <= tick_tc ? '0 : tick_cnt + 1'b1;
      move_pend <= pend_nxt;
      pos_x     <= pos_x_nxt;
      pos_y     <= pos_y_nxt;
      dir_x     <= dir_x_nxt;
      dir_y     <= dir_y_nxt;
    end
  end

endmodule
